// File: rtl/display_serializer.sv
// display_serializer: BCD frame -> 7-segment bytes shifted out to a 595-style chain, then latched.
// Optional DISPLAY_SER_LZB_EN enables leading-zero blanking.  Rev 1.0
`default_nettype none

module display_serializer #(
  parameter int DIGITS    = 4,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic                  ser_data,
  output logic                  ser_clk,
  output logic                  ser_latch,
  output logic                  busy,
  output logic                  done
);

  localparam int NBITS = 8 * DIGITS;
  localparam int CNT_W = $clog2(NBITS);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [NBITS-2:0]       r_shreg;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [DIV_W-1:0]       r_div_cnt;

  logic [NBITS-1:0]       w_frame;
  logic [NBITS-2:0]       w_load;
  logic [NBITS-2:0]       w_shift;
  logic                   w_first;
  logic                   w_next;

  function automatic logic [7:0] seg7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'd0:    s = 8'hFC;
      4'd1:    s = 8'h60;
      4'd2:    s = 8'hDA;
      4'd3:    s = 8'hF2;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'hB6;
      4'd6:    s = 8'hBE;
      4'd7:    s = 8'hE0;
      4'd8:    s = 8'hFE;
      4'd9:    s = 8'hF6;
      default: s = 8'h02;
    endcase
    return s;
  endfunction

  function automatic logic [NBITS-1:0] encode_frame(input logic [4*DIGITS-1:0] bcd,
                                                    input logic [DIGITS-1:0]   dp);
    logic [NBITS-1:0] f;
    logic [7:0]       code;
`ifdef DISPLAY_SER_LZB_EN
    logic             lead;
    lead = 1'b1;
`endif
    f = '0;
    // Walk from the most significant digit so blanking stops at the first nonzero nibble.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      code = seg7(bcd[4*i +: 4]);
`ifdef DISPLAY_SER_LZB_EN
      if (bcd[4*i +: 4] != 4'd0) lead = 1'b0;
      if (lead && (i != 0)) code = 8'h00;
`endif
      f[8*i +: 8] = code | {7'd0, dp[i]};
    end
    return f;
  endfunction

  assign w_frame = encode_frame(bcd_in, dp_in);

  // ser_data holds the bit in flight; the shift register only keeps the bits still to come.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_first = w_frame[NBITS-1];
      assign w_load  = w_frame[NBITS-2:0];
      assign w_next  = r_shreg[NBITS-2];
      assign w_shift = {r_shreg[NBITS-3:0], 1'b0};
    end else begin : g_lsb_first
      assign w_first = w_frame[0];
      assign w_load  = w_frame[NBITS-1:1];
      assign w_next  = r_shreg[0];
      assign w_shift = {1'b0, r_shreg[NBITS-2:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      in_ready  <= 1'b1;
      ser_data  <= 1'b0;
      ser_clk   <= 1'b0;
      ser_latch <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            r_state   <= S_SHIFT;
            r_shreg   <= w_load;
            ser_data  <= w_first;
            ser_clk   <= 1'b0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end

        S_SHIFT: begin
          if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            if (!ser_clk) begin
              ser_clk <= 1'b1;
            end else begin
              ser_clk <= 1'b0;
              if (r_bit_cnt == LAST_BIT) begin
                r_state   <= S_LATCH;
                ser_data  <= 1'b0;
                ser_latch <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                ser_data  <= w_next;
                r_shreg   <= w_shift;
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end

        S_LATCH: begin
          if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            ser_latch <= 1'b0;
            done      <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end

        S_DONE: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
          r_state  <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
